// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 byte transmitter.
//
// Sends one command byte (e.g. 0xED + LED mask, 0xFF reset) to a PS/2 device
// using the device-clocked host protocol: the clock is held low, the start bit
// is requested, and then the device clocks out data, parity and stop. Both pins
// are open-drain, so this block only produces pull-low enables.
//
// Ports:
//   CLOCK_50            system clock
//   reset               synchronous, active-high
//   cmd_data/cmd_valid  byte to send; accepted when cmd_valid && cmd_ready
//   cmd_ready           high in IDLE (not during the done/error pulse cycle)
//   ps2_clk_in/dat_in   raw pin levels (synchronised internally)
//   ps2_clk_oe/dat_oe   1 = pull the line low, 0 = release
//   busy                high outside IDLE
//   done / error        one-cycle completion / failure pulses
//
// Optional build macro PS2_LED_CMD_EN adds led_req/led_mask: a request sends
// 0xED, waits for an idle bus, then sends {5'b0, led_mask} with a single done.

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
`ifdef PS2_LED_CMD_EN
    input  logic       led_req,
    input  logic [2:0] led_mask,
`endif
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_RTS      = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_WAIT_REL = 3'd5;
`ifdef PS2_LED_CMD_EN
    localparam logic [2:0] S_GAP      = 3'd6;
`endif

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]             state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_cur;
    logic                   dat_cur;
    logic                   fall;
    logic [9:0]             shreg;
    logic [3:0]             bit_cnt;
    logic [INH_W-1:0]       inh_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   dat_oe_q;
`ifdef PS2_LED_CMD_EN
    logic                   led_first;
    logic [2:0]             led_mask_q;
`endif

    // {stop, odd parity, data}; bit 0 goes out first.
    function automatic logic [9:0] frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    // Idle bus level is high, so the synchronisers reset to 1 to avoid a
    // phantom falling edge straight out of reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_in};
            clk_prev <= clk_cur;
        end
    end

    assign clk_cur = clk_sync[SYNC_STAGES-1];
    assign dat_cur = dat_sync[SYNC_STAGES-1];
    assign fall    = clk_prev & ~clk_cur;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            dat_oe_q   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef PS2_LED_CMD_EN
            led_first  <= 1'b0;
            led_mask_q <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    dat_oe_q <= 1'b0;
                    inh_cnt  <= '0;
`ifdef PS2_LED_CMD_EN
                    if (led_req && cmd_ready) begin
                        shreg      <= frame(8'hED);
                        led_first  <= 1'b1;
                        led_mask_q <= led_mask;
                        state      <= S_INHIBIT;
                    end else
`endif
                    if (cmd_valid && cmd_ready) begin
                        shreg <= frame(cmd_data);
                        state <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        dat_oe_q <= 1'b1;  // start bit, visible in the first RTS cycle
                        state    <= S_RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_RTS: begin
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                    state   <= S_SEND;
                end
                S_SEND, S_ACK, S_WAIT_REL: begin
                    tmo_cnt <= fall ? '0 : tmo_cnt + 1'b1;
                    // An edge in the timeout cycle wins over the timeout.
                    if (!fall && tmo_cnt == TMO_LAST) begin
                        error    <= 1'b1;
                        dat_oe_q <= 1'b0;
                        state    <= S_IDLE;
`ifdef PS2_LED_CMD_EN
                        led_first <= 1'b0;
`endif
                    end else begin
                        case (state)
                            S_SEND: if (fall) begin
                                dat_oe_q <= ~shreg[0];
                                shreg    <= {1'b0, shreg[9:1]};
                                bit_cnt  <= bit_cnt + 1'b1;
                                if (bit_cnt == 4'd9) state <= S_ACK;
                            end
                            S_ACK: if (fall) begin
                                if (!dat_cur) begin
                                    state <= S_WAIT_REL;
                                end else begin
                                    error <= 1'b1;
                                    state <= S_IDLE;
`ifdef PS2_LED_CMD_EN
                                    led_first <= 1'b0;
`endif
                                end
                            end
                            default: if (clk_cur && dat_cur) begin
`ifdef PS2_LED_CMD_EN
                                if (led_first) begin
                                    led_first <= 1'b0;
                                    inh_cnt   <= '0;
                                    state     <= S_GAP;
                                end else
`endif
                                begin
                                    done  <= 1'b1;
                                    state <= S_IDLE;
                                end
                            end
                        endcase
                    end
                end
`ifdef PS2_LED_CMD_EN
                // Bus must be idle (clk = dat = 1) for a full inhibit period
                // before the mask byte; any low level restarts the count.
                S_GAP: begin
                    if (clk_cur && dat_cur) begin
                        if (inh_cnt == INH_LAST) begin
                            shreg   <= frame({5'b0, led_mask_q});
                            inh_cnt <= '0;
                            state   <= S_INHIBIT;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end else begin
                        inh_cnt <= '0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ps2_clk_oe = (state == S_INHIBIT);
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = (state != S_IDLE);
    assign cmd_ready  = (state == S_IDLE) && !done && !error;

endmodule
